// File: rtl/pipe_pkg.sv
// Shared EX->MEM pipeline types: the beat carried between stages and NZCV flag indices.
package pipe_pkg;

   localparam int unsigned PIPE_DATA_W = 18;
   localparam int unsigned PIPE_REG_AW = 4;

   localparam int unsigned FLG_N = 3;
   localparam int unsigned FLG_Z = 2;
   localparam int unsigned FLG_C = 1;
   localparam int unsigned FLG_V = 0;

   typedef struct packed {
      logic [PIPE_DATA_W-1:0] result;
      logic [PIPE_DATA_W-1:0] store_data;
      logic [PIPE_REG_AW-1:0] rd;
      logic                   reg_write;
      logic                   mem_read;
      logic                   mem_write;
   } ex_mem_t;

   // Pack ALU flags into the architectural {N,Z,C,V} order.
   function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                            input logic c, input logic v);
      logic [3:0] f;
      f        = '0;
      f[FLG_N] = n;
      f[FLG_Z] = z;
      f[FLG_C] = c;
      f[FLG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready register slice. in_ready is a flop, so no path
// from in_valid/out_ready reaches it combinationally.
module skid_buffer #(
   parameter type T = logic
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e state_q;
   T       main_q;
   T       skid_q;
   logic   in_ready_q;
   logic   out_valid_q;
   logic   accept;
   logic   deliver;

   assign accept  = in_valid && in_ready_q;
   assign deliver = out_valid_q && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StEmpty;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         state_q     <= StEmpty;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            StEmpty: begin
               if (accept) begin
                  main_q      <= in_data;
                  state_q     <= StOne;
                  out_valid_q <= 1'b1;
               end
            end
            StOne: begin
               if (accept && deliver) begin
                  main_q <= in_data;
               end else if (accept) begin
                  // Main is stalled; park the new beat and drop ready.
                  skid_q     <= in_data;
                  state_q    <= StFull;
                  in_ready_q <= 1'b0;
               end else if (deliver) begin
                  state_q     <= StEmpty;
                  out_valid_q <= 1'b0;
               end
            end
            StFull: begin
               if (deliver) begin
                  main_q     <= skid_q;
                  state_q    <= StOne;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= StEmpty;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: skid-buffered beat transport plus the NZCV
// condition-code register updated by accepted set_flags instructions.
module ex_mem_stage
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = PIPE_DATA_W,
   parameter int unsigned REG_AW = PIPE_REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [DATA_W-1:0] ex_result,
   input  logic              ex_ovf,
   input  logic              ex_carry,
   input  logic              ex_zero,
   input  logic              ex_neg,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic              ex_set_flags,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] mem_result,
   output logic [DATA_W-1:0] mem_store_data,
   output logic [REG_AW-1:0] mem_rd,
   output logic              mem_reg_write,
   output logic              mem_mem_read,
   output logic              mem_mem_write,
   output logic [3:0]        flags_nzcv
);

   ex_mem_t    ex_beat;
   ex_mem_t    mem_beat;
   logic       ex_accept;
   logic [3:0] flags_q;

   always_comb begin
      ex_beat            = '0;
      ex_beat.result     = ex_result;
      ex_beat.store_data = ex_store_data;
      ex_beat.rd         = ex_rd;
      ex_beat.reg_write  = ex_reg_write;
      ex_beat.mem_read   = ex_mem_read;
      ex_beat.mem_write  = ex_mem_write;
   end

   skid_buffer #(
      .T(ex_mem_t)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (ex_valid),
      .in_ready (ex_ready),
      .in_data  (ex_beat),
      .out_valid(mem_valid),
      .out_ready(mem_ready),
      .out_data (mem_beat)
   );

   assign ex_accept = ex_valid && ex_ready;

   // A flushed beat is squashed, so it must not commit flags either.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 4'b0000;
      end else if (!flush && ex_accept && ex_set_flags) begin
         flags_q <= pack_nzcv(ex_neg, ex_zero, ex_carry, ex_ovf);
      end
   end

   assign flags_nzcv     = flags_q;
   assign mem_result     = mem_beat.result;
   assign mem_store_data = mem_beat.store_data;
   assign mem_rd         = mem_beat.rd;
   assign mem_reg_write  = mem_beat.reg_write;
   assign mem_mem_read   = mem_beat.mem_read;
   assign mem_mem_write  = mem_beat.mem_write;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: streaming, backpressure, flags, flush and async reset.
module tb_ex_mem_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [17:0] ex_result;
   logic        ex_ovf;
   logic        ex_carry;
   logic        ex_zero;
   logic        ex_neg;
   logic [17:0] ex_store_data;
   logic [3:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_set_flags;
   logic        mem_valid;
   logic        mem_ready;
   logic [17:0] mem_result;
   logic [17:0] mem_store_data;
   logic [3:0]  mem_rd;
   logic        mem_reg_write;
   logic        mem_mem_read;
   logic        mem_mem_write;
   logic [3:0]  flags_nzcv;

   int checks = 0;
   int errors = 0;

   ex_mem_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .ex_valid      (ex_valid),
      .ex_ready      (ex_ready),
      .ex_result     (ex_result),
      .ex_ovf        (ex_ovf),
      .ex_carry      (ex_carry),
      .ex_zero       (ex_zero),
      .ex_neg        (ex_neg),
      .ex_store_data (ex_store_data),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write),
      .ex_set_flags  (ex_set_flags),
      .mem_valid     (mem_valid),
      .mem_ready     (mem_ready),
      .mem_result    (mem_result),
      .mem_store_data(mem_store_data),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .mem_mem_read  (mem_mem_read),
      .mem_mem_write (mem_mem_write),
      .flags_nzcv    (flags_nzcv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Side fields are derived from the result so every beat is distinguishable.
   task automatic drive(input logic v, input logic [17:0] res, input logic n, input logic z,
                        input logic c, input logic o, input logic sf);
      ex_valid      = v;
      ex_result     = res;
      ex_neg        = n;
      ex_zero       = z;
      ex_carry      = c;
      ex_ovf        = o;
      ex_set_flags  = sf;
      ex_store_data = res ^ 18'h2AAAA;
      ex_rd         = res[3:0];
      ex_reg_write  = 1'b1;
      ex_mem_read   = res[0];
      ex_mem_write  = res[1];
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      mem_ready = 1'b0;
      drive(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #12;
      chk("reset_mem_valid", {31'd0, mem_valid}, 32'd0);
      chk("reset_ex_ready", {31'd0, ex_ready}, 32'd1);
      chk("reset_flags", {28'd0, flags_nzcv}, 32'd0);
      rst_n = 1'b1;
      step();

      // Stream of 4 beats, no backpressure.
      mem_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 18'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         step();
         chk($sformatf("stream_valid_%0d", k), {31'd0, mem_valid}, 32'd1);
         chk($sformatf("stream_result_%0d", k), {14'd0, mem_result}, 32'(k));
         chk($sformatf("stream_ready_%0d", k), {31'd0, ex_ready}, 32'd1);
      end
      chk("stream_store", {14'd0, mem_store_data}, 32'(18'h4 ^ 18'h2AAAA));
      chk("stream_rd", {28'd0, mem_rd}, 32'd4);
      chk("stream_ctrl", {29'd0, mem_reg_write, mem_mem_read, mem_mem_write}, 32'b100);
      drive(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("stream_drain", {31'd0, mem_valid}, 32'd0);

      // Backpressure: 3 beats with mem_ready low for 3 cycles.
      mem_ready = 1'b0;
      drive(1'b1, 18'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("bp_one_result", {14'd0, mem_result}, 32'h11);
      chk("bp_one_ready", {31'd0, ex_ready}, 32'd1);
      drive(1'b1, 18'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("bp_full_ready", {31'd0, ex_ready}, 32'd0);
      chk("bp_full_hold", {14'd0, mem_result}, 32'h11);
      drive(1'b1, 18'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("bp_stall_hold", {14'd0, mem_result}, 32'h11);
      chk("bp_stall_valid", {31'd0, mem_valid}, 32'd1);
      mem_ready = 1'b1;
      step();
      chk("bp_second", {14'd0, mem_result}, 32'h12);
      chk("bp_ready_back", {31'd0, ex_ready}, 32'd1);
      step();
      chk("bp_third", {14'd0, mem_result}, 32'h13);
      chk("bp_third_valid", {31'd0, mem_valid}, 32'd1);
      drive(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("bp_drain", {31'd0, mem_valid}, 32'd0);

      // Flags: SUB sets N; following ADD without set_flags leaves them.
      drive(1'b1, 18'h20000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      chk("flags_sub", {28'd0, flags_nzcv}, 32'b1000);
      chk("flags_sub_result", {14'd0, mem_result}, 32'h20000);
      drive(1'b1, 18'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      chk("flags_add_kept", {28'd0, flags_nzcv}, 32'b1000);
      chk("flags_add_result", {14'd0, mem_result}, 32'h5);
      drive(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();

      // Flush while FULL with an incoming set_flags beat.
      mem_ready = 1'b0;
      drive(1'b1, 18'h21, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 18'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("flush_pre_full", {31'd0, ex_ready}, 32'd0);
      flush = 1'b1;
      drive(1'b1, 18'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      chk("flush_full_valid", {31'd0, mem_valid}, 32'd0);
      chk("flush_full_ready", {31'd0, ex_ready}, 32'd1);
      chk("flush_full_flags", {28'd0, flags_nzcv}, 32'b1000);
      // Now ex_ready=1, so the flushed beat would otherwise be accepted.
      step();
      chk("flush_accept_valid", {31'd0, mem_valid}, 32'd0);
      chk("flush_accept_flags", {28'd0, flags_nzcv}, 32'b1000);
      flush     = 1'b0;
      mem_ready = 1'b1;
      drive(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("flush_after_valid", {31'd0, mem_valid}, 32'd0);

      // Overflow/carry flags and bit-exact passthrough.
      drive(1'b1, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      step();
      chk("ovf_flags", {28'd0, flags_nzcv}, 32'b0011);
      chk("ovf_result", {14'd0, mem_result}, 32'h3FFFF);
      chk("ovf_store", {14'd0, mem_store_data}, 32'(18'h3FFFF ^ 18'h2AAAA));
      chk("ovf_ctrl", {28'd0, mem_rd}, 32'hF);
      drive(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();

      // Async reset mid-cycle while FULL.
      mem_ready = 1'b0;
      drive(1'b1, 18'h31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 18'h32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("arst_pre_full", {31'd0, ex_ready}, 32'd0);
      chk("arst_pre_flags", {28'd0, flags_nzcv}, 32'b0011);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, mem_valid}, 32'd0);
      chk("arst_flags", {28'd0, flags_nzcv}, 32'd0);
      chk("arst_ready", {31'd0, ex_ready}, 32'd1);
      drive(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #10;
      rst_n = 1'b1;
      step();
      chk("arst_after_valid", {31'd0, mem_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
